// File: rtl/beat_seq_pkg.sv
// Shared definitions for the beat sequencer: FSM states, score-word field
// positions, setting op codes and the note-duration decode helper.
package beat_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DECODE = 3'd3,
    ST_PLAY   = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [2:0] OP_SET_BPM = 3'd0;
  localparam logic [2:0] OP_JUMP    = 3'd1;
  localparam logic [2:0] OP_HALT    = 3'd7;

  localparam int KIND_BIT  = 0;
  localparam int NOTE_LSB  = 1;
  localparam int NOTE_MSB  = 7;
  localparam int BEATS_LSB = 8;
  localparam int BEATS_MSB = 11;
  localparam int OP_LSB    = 1;
  localparam int OP_MSB    = 3;
  localparam int BPM_LSB   = 8;
  localparam int BPM_MSB   = 15;
  localparam int TGT_LSB   = 4;
  localparam int TGT_MSB   = 15;

  localparam logic [4:0] DUR_ZERO_BEATS = 5'd16;

  // A zero beat field encodes the longest note rather than an empty one.
  function automatic logic [4:0] note_beats(input logic [3:0] field);
    if (field == 4'd0) begin
      return DUR_ZERO_BEATS;
    end else begin
      return {1'b0, field};
    end
  endfunction

endpackage

// File: rtl/beat_timer.sv
// Beat phase accumulator: adds bpm every enabled cycle and ticks whenever the
// running sum crosses one minute of clock cycles, keeping the remainder.
module beat_timer #(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] bpm,
  output logic       tick
);

  // Computed in 64 bits so 60*CLK_HZ cannot overflow a signed 32-bit int.
  localparam logic [63:0] MINUTE_W = 64'(CLK_HZ) * 64'd60;
  localparam logic [32:0] MINUTE   = MINUTE_W[32:0];

  logic [31:0] acc_r;
  logic [32:0] sum_s;
  logic [32:0] wrap_s;

  // Next accumulator value and the crossing test.
  always_comb begin
    sum_s  = {1'b0, acc_r} + {25'd0, bpm};
    wrap_s = sum_s - MINUTE;
    if (enable) begin
      tick = (sum_s >= MINUTE);
    end else begin
      tick = 1'b0;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= 32'd0;
    end else if (clear) begin
      acc_r <= 32'd0;
    end else if (enable) begin
      if (tick) begin
        acc_r <= wrap_s[31:0];
      end else begin
        acc_r <= sum_s[31:0];
      end
    end
  end

endmodule

// File: rtl/beat_sequencer.sv
// Score sequencer: fetches 16-bit words from SRAM, executes settings and holds
// each note for its beat count at the current tempo.
module beat_sequencer
  import beat_seq_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned READ_LAT    = 2,
  parameter logic [7:0]  DEFAULT_BPM = 8'd96
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [15:0]       mem_data,
  output logic [6:0]        note,
  output logic              gate,
  output logic [7:0]        bpm,
  output logic              halted
);

  localparam int unsigned       LAT_W     = $clog2(READ_LAT + 1);
  localparam logic [LAT_W-1:0]  LAST_WAIT = LAT_W'(READ_LAT - 1);
  localparam logic [LAT_W-1:0]  WAIT_STEP = LAT_W'(1'b1);
  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(1'b1);

  state_t            state_r;
  logic [ADDR_W-1:0] pc_r;
  logic [15:0]       ir_r;
  logic [4:0]        beats_left_r;
  logic [LAT_W-1:0]  wait_cnt_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic              mem_rd_r;
  logic [6:0]        note_r;
  logic              gate_r;
  logic [7:0]        bpm_r;
  logic              halted_r;

  logic              is_note_s;
  logic [2:0]        op_s;
  logic [ADDR_W-1:0] pc_inc_s;
  logic [ADDR_W-1:0] jump_tgt_s;
  logic [7:0]        new_bpm_s;
  logic              timer_clear_s;
  logic              timer_en_s;
  logic              tick_s;

  // Field extraction from the instruction register and timer control.
  always_comb begin
    is_note_s     = ir_r[KIND_BIT];
    op_s          = ir_r[OP_MSB:OP_LSB];
    pc_inc_s      = pc_r + PC_STEP;
    jump_tgt_s    = ADDR_W'(ir_r[TGT_MSB:TGT_LSB]);
    new_bpm_s     = ir_r[BPM_MSB:BPM_LSB];
    timer_clear_s = (state_r == ST_DECODE);
    timer_en_s    = (state_r == ST_PLAY);
  end

  beat_timer #(
    .CLK_HZ (CLK_HZ)
  ) u_beat_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear_s),
    .enable (timer_en_s),
    .bpm    (bpm_r),
    .tick   (tick_s)
  );

  // Fetch/play state machine with registered SRAM and note outputs.
  // Pausing wins over every state except HALT; pc is only moved by DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      pc_r         <= '0;
      ir_r         <= 16'd0;
      beats_left_r <= 5'd0;
      wait_cnt_r   <= '0;
      mem_addr_r   <= '0;
      mem_rd_r     <= 1'b0;
      note_r       <= 7'd0;
      gate_r       <= 1'b0;
      bpm_r        <= DEFAULT_BPM;
      halted_r     <= 1'b0;
    end else if ((state_r != ST_HALT) && !run) begin
      state_r  <= ST_IDLE;
      gate_r   <= 1'b0;
      mem_rd_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r    <= ST_FETCH;
          mem_rd_r   <= 1'b1;
          mem_addr_r <= pc_r;
        end
        ST_FETCH: begin
          state_r    <= ST_WAIT;
          mem_rd_r   <= 1'b0;
          wait_cnt_r <= '0;
        end
        ST_WAIT: begin
          if (wait_cnt_r == LAST_WAIT) begin
            ir_r    <= mem_data;
            state_r <= ST_DECODE;
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_STEP;
          end
        end
        ST_DECODE: begin
          if (is_note_s) begin
            note_r       <= ir_r[NOTE_MSB:NOTE_LSB];
            gate_r       <= (ir_r[NOTE_MSB:NOTE_LSB] != 7'd0);
            beats_left_r <= note_beats(ir_r[BEATS_MSB:BEATS_LSB]);
            pc_r         <= pc_inc_s;
            state_r      <= ST_PLAY;
          end else begin
            case (op_s)
              OP_SET_BPM: begin
                if (new_bpm_s != 8'd0) begin
                  bpm_r <= new_bpm_s;
                end
                pc_r       <= pc_inc_s;
                mem_addr_r <= pc_inc_s;
                mem_rd_r   <= 1'b1;
                state_r    <= ST_FETCH;
              end
              OP_JUMP: begin
                pc_r       <= jump_tgt_s;
                mem_addr_r <= jump_tgt_s;
                mem_rd_r   <= 1'b1;
                state_r    <= ST_FETCH;
              end
              OP_HALT: begin
                halted_r <= 1'b1;
                gate_r   <= 1'b0;
                state_r  <= ST_HALT;
              end
              default: begin
                pc_r       <= pc_inc_s;
                mem_addr_r <= pc_inc_s;
                mem_rd_r   <= 1'b1;
                state_r    <= ST_FETCH;
              end
            endcase
          end
        end
        ST_PLAY: begin
          if (tick_s) begin
            if (beats_left_r == 5'd1) begin
              state_r    <= ST_FETCH;
              mem_rd_r   <= 1'b1;
              mem_addr_r <= pc_r;
            end else begin
              beats_left_r <= beats_left_r - 5'd1;
            end
          end
        end
        ST_HALT: begin
          state_r <= ST_HALT;
        end
        default: begin
          state_r  <= ST_IDLE;
          mem_rd_r <= 1'b0;
          gate_r   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr = mem_addr_r;
  assign mem_rd   = mem_rd_r;
  assign note     = note_r;
  assign gate     = gate_r;
  assign bpm      = bpm_r;
  assign halted   = halted_r;

endmodule

// File: tb/tb_beat_sequencer.sv
// Bench for beat_sequencer: SRAM model plus an event-level score interpreter
// that predicts fetch times and note/tempo changes from beat arithmetic.
module tb_beat_sequencer;

  localparam int AW   = 12;
  localparam int RL   = 2;
  localparam int PER  = 600;
  localparam int MAXC = 1200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [15:0]   mem_data;
  logic [6:0]    note;
  logic          gate;
  logic [7:0]    bpm;
  logic          halted;

  logic [15:0]   mem  [0:(1<<AW)-1];
  logic [15:0]   pipe [0:RL-1];

  logic          exp_rd   [MAXC];
  logic [AW-1:0] exp_addr [MAXC];
  logic [6:0]    exp_note [MAXC];
  logic          exp_gate [MAXC];
  logic [7:0]    exp_bpm  [MAXC];
  logic          exp_halt [MAXC];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  beat_sequencer #(
    .CLK_HZ      (10),
    .ADDR_W      (AW),
    .READ_LAT    (RL),
    .DEFAULT_BPM (8'd96)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_data (mem_data),
    .note     (note),
    .gate     (gate),
    .bpm      (bpm),
    .halted   (halted)
  );

  // SRAM: data appears RL cycles after the strobe; junk otherwise.
  always @(posedge clk) begin
    pipe[0] <= mem_rd ? mem[mem_addr] : 16'h5A5B;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_data = pipe[RL-1];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic rd, input logic [AW-1:0] a, input logic [6:0] n,
                                       input logic g, input logic [7:0] b, input logic h);
    logic [AW-1:0] am;
    am = rd ? a : '0;
    return 64'({rd, am, n, g, b, h});
  endfunction

  function automatic logic [63:0] obs_vec();
    return pack(mem_rd, mem_addr, note, gate, bpm, halted);
  endfunction

  task automatic fill_from(input int t0, input int n, input logic [6:0] nt, input logic g,
                           input logic [7:0] b, input logic h);
    for (int k = t0; k < n; k++) begin
      exp_note[k] = nt; exp_gate[k] = g; exp_bpm[k] = b; exp_halt[k] = h;
    end
  endtask

  // Interpret the score: a note of d beats at b bpm lasts ceil(d*PER/b) cycles.
  task automatic build_model(input int n);
    int t, te, d, c;
    logic [AW-1:0] pc;
    logic [15:0]   w;
    logic [6:0]    nt;
    logic          g, h;
    logic [7:0]    b;
    pc = '0; nt = 7'd0; g = 1'b0; h = 1'b0; b = 8'd96; t = 0;
    for (int k = 0; k < n; k++) begin
      exp_rd[k] = 1'b0; exp_addr[k] = '0;
    end
    fill_from(0, n, nt, g, b, h);
    while (t < n && !h) begin
      exp_rd[t] = 1'b1; exp_addr[t] = pc;
      w  = mem[pc];
      te = t + RL + 2;
      if (w[0]) begin
        nt = w[7:1];
        g  = (nt != 7'd0);
        d  = (w[11:8] == 4'd0) ? 16 : int'(w[11:8]);
        c  = (d * PER + int'(b) - 1) / int'(b);
        pc = pc + 12'd1;
        t  = te + c;
      end else begin
        case (w[3:1])
          3'd0: begin
            if (w[15:8] != 8'd0) b = w[15:8];
            pc = pc + 12'd1;
          end
          3'd1: pc = w[15:4];
          3'd7: begin h = 1'b1; g = 1'b0; end
          default: pc = pc + 12'd1;
        endcase
        t = te;
      end
      fill_from(te, n, nt, g, b, h);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < (1<<AW); i++) mem[i] = 16'h000E;
  endtask

  task automatic do_reset();
    run = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset", obs_vec(), pack(1'b0, '0, 7'd0, 1'b0, 8'd96, 1'b0));
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_program(input string tag, input int n);
    do_reset();
    build_model(n);
    run = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_val($sformatf("%s@%0d", tag, k), obs_vec(),
                pack(exp_rd[k], exp_addr[k], exp_note[k], exp_gate[k], exp_bpm[k], exp_halt[k]));
      if (exp_halt[k]) run = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic gen_program();
    int len;
    len = $urandom_range(3, 9);
    clear_mem();
    for (int i = 0; i < len; i++) begin
      int r;
      logic [15:0] w;
      r = $urandom_range(0, 9);
      if (r < 6) begin
        w[0]     = 1'b1;
        w[7:1]   = 7'($urandom);
        w[11:8]  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
        w[15:12] = 4'($urandom);
      end else if (r < 8) begin
        w = {(($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(30, 255))), 4'($urandom), 3'd0, 1'b0};
      end else begin
        w = {12'($urandom), 3'($urandom_range(2, 6)), 1'b0};
      end
      mem[i] = w;
    end
    mem[len] = ($urandom_range(0, 3) == 0) ? 16'h000E : {12'($urandom_range(0, len - 1)), 3'd1, 1'b0};
  endtask

  initial begin
    // Single note at the default tempo.
    clear_mem(); mem[0] = 16'h0181;
    run_program("t1_note", 40);
    // Tempo setting then a 2-beat note at 60 bpm.
    clear_mem(); mem[0] = 16'h3C00; mem[1] = 16'h0283;
    run_program("t2_setbpm", 60);
    // Rest with zero duration field means 16 beats.
    clear_mem(); mem[0] = 16'h3C00; mem[1] = 16'h0001;
    run_program("t3_rest16", 200);
    // Jump back to 0 after two notes.
    clear_mem(); mem[0] = 16'h0181; mem[1] = 16'h0183; mem[2] = 16'h0002;
    run_program("t4_jump", 80);
    // Jump to the last address, then pc wraps to 0.
    clear_mem(); mem[0] = 16'hFFF2; mem[(1<<AW)-1] = 16'h0185;
    run_program("t4_wrap", 60);
    // HALT: no further reads, run toggling ignored.
    clear_mem(); mem[0] = 16'h0181; mem[1] = 16'h000E;
    run_program("t5_halt", 120);
    for (int p = 0; p < 6; p++) begin
      gen_program();
      run_program($sformatf("rand%0d", p), 400);
    end

    // Pause mid-note, resume at the following word, then reset mid-WAIT.
    clear_mem(); mem[0] = 16'h3C00; mem[1] = 16'h0581; mem[2] = 16'h0183;
    do_reset();
    build_model(20);
    run = 1'b1;
    for (int k = 0; k < 40; k++) begin
      logic [63:0] e;
      @(negedge clk);
      if (k < 20)       e = pack(exp_rd[k], exp_addr[k], exp_note[k], exp_gate[k], exp_bpm[k], exp_halt[k]);
      else if (k == 25) e = pack(1'b1, 12'd2, 7'd64, 1'b0, 8'd60, 1'b0);
      else if (k < 29)  e = pack(1'b0, '0, 7'd64, 1'b0, 8'd60, 1'b0);
      else if (k < 39)  e = pack(1'b0, '0, 7'd65, 1'b1, 8'd60, 1'b0);
      else              e = pack(1'b1, 12'd3, 7'd65, 1'b1, 8'd60, 1'b0);
      check_val($sformatf("t6_pause@%0d", k), obs_vec(), e);
      if (k == 19) run = 1'b0;
      if (k == 24) run = 1'b1;
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_val("t6_async_rst", obs_vec(), pack(1'b0, '0, 7'd0, 1'b0, 8'd96, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    run = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
